port_alloc_sched: RTL and testbench

PORT_ALLOC_SCHED -- requirements
Module: port_alloc_sched

---
 rtl/port_alloc_sched_pkg.sv | 11 +
 rtl/port_alloc_sched_alloc_stage.sv | 30 +++
 rtl/port_alloc_sched.sv | 183 ++++++++++++++++++
 tb/tb_port_alloc_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/port_alloc_sched_pkg.sv
// Shared constants for the port allocator: default port count,
// starvation counter width and default starvation threshold.
package port_alloc_sched_pkg;

    localparam int PAS_NUM_PORT  = 4;
    localparam int PAS_CNT_W     = 3;
    localparam int PAS_STARVE_TH = 4;

    localparam logic [PAS_CNT_W-1:0] PAS_CNT_MAX = '1;

endpackage

// File: rtl/port_alloc_sched_alloc_stage.sv
// One link of the allocation chain: picks the lowest free productive
// port, else the lowest free port, and passes the remaining ports on.
module alloc_stage
    import port_alloc_sched_pkg::*;
#(
    parameter int N = PAS_NUM_PORT
) (
    input  logic [N-1:0] avail_in,
    input  logic         valid,
    input  logic [N-1:0] ppv,
    output logic [N-1:0] grant,
    output logic [N-1:0] avail_out,
    output logic         deflect
);

    logic [N-1:0] prod;
    logic [N-1:0] cand;
    logic         miss;

    always_comb begin
        prod      = ppv & avail_in;
        miss      = (ppv != '0) && (prod == '0);
        cand      = ((ppv == '0) || miss) ? avail_in : prod;
        // isolate lowest set bit of the candidate set
        grant     = valid ? (cand & (~cand + N'(1))) : '0;
        avail_out = avail_in & ~grant;
        deflect   = valid & miss;
    end

endmodule

// File: rtl/port_alloc_sched.sv
// Single-cycle bufferless output-port allocator with round-robin priority.
// Define PORT_ALLOC_STARVE_EN to add per-input starvation counters / golden input.
module port_alloc_sched
    import port_alloc_sched_pkg::*;
#(
    parameter int NUM_PORT  = PAS_NUM_PORT,
    parameter int STARVE_TH = PAS_STARVE_TH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORT-1:0]          in_valid,
    input  logic [NUM_PORT*NUM_PORT-1:0] in_ppv,
    output logic [NUM_PORT-1:0]          out_valid,
    output logic [NUM_PORT*NUM_PORT-1:0] out_grant,
    output logic [NUM_PORT-1:0]          out_deflect,
    output logic [NUM_PORT-1:0]          out_golden
);

    localparam int IW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_PORT - 1);

    localparam bit STARVE_ON =
`ifdef PORT_ALLOC_STARVE_EN
        (STARVE_TH >= 1) && (STARVE_TH <= 7);
`else
        1'b0 && (STARVE_TH >= 1);
`endif

    logic [IW-1:0]                rr_q, rr_d;
    logic                         gold_vld;
    logic [IW-1:0]                gold_idx;
    logic [IW-1:0]                ord [NUM_PORT];
    logic [NUM_PORT-1:0]          avail [NUM_PORT];
    logic [NUM_PORT-1:0]          avail_unused;
    logic [NUM_PORT-1:0]          s_valid;
    logic [NUM_PORT-1:0]          s_defl;
    logic [NUM_PORT-1:0]          s_ppv [NUM_PORT];
    logic [NUM_PORT-1:0]          s_grant [NUM_PORT];
    logic [NUM_PORT*NUM_PORT-1:0] grant_c;
    logic [NUM_PORT-1:0]          defl_c;
    logic [NUM_PORT-1:0]          gold_c;

    logic [NUM_PORT-1:0]          out_valid_q;
    logic [NUM_PORT*NUM_PORT-1:0] out_grant_q;
    logic [NUM_PORT-1:0]          out_deflect_q;
    logic [NUM_PORT-1:0]          out_golden_q;

    // visit order: golden first, then round-robin from rr_q skipping golden
    always_comb begin
        logic [IW:0]   n;
        logic [IW-1:0] p;
        n = '0;
        p = rr_q;
        for (int k = 0; k < NUM_PORT; k++) begin
            ord[k] = '0;
        end
        if (gold_vld) begin
            ord[0] = gold_idx;
            n      = (IW+1)'(1);
        end
        for (int k = 0; k < NUM_PORT; k++) begin
            if (!(gold_vld && (p == gold_idx))) begin
                ord[n[IW-1:0]] = p;
                n              = n + 1'b1;
            end
            p = (p == LAST) ? '0 : p + 1'b1;
        end
    end

    assign avail[0] = '1;

    for (genvar k = 0; k < NUM_PORT; k++) begin : g_stage
        logic [NUM_PORT-1:0] a_out;

        assign s_valid[k] = in_valid[ord[k]];
        assign s_ppv[k]   = in_ppv[ord[k]*NUM_PORT +: NUM_PORT];

        alloc_stage #(
            .N (NUM_PORT)
        ) u_alloc (
            .avail_in  (avail[k]),
            .valid     (s_valid[k]),
            .ppv       (s_ppv[k]),
            .grant     (s_grant[k]),
            .avail_out (a_out),
            .deflect   (s_defl[k])
        );

        if (k < NUM_PORT - 1) begin : g_link
            assign avail[k+1] = a_out;
        end else begin : g_tail
            assign avail_unused = a_out;
        end
    end

    always_comb begin
        grant_c = '0;
        defl_c  = '0;
        gold_c  = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            grant_c[ord[k]*NUM_PORT +: NUM_PORT] = s_grant[k];
            defl_c[ord[k]]                       = s_defl[k];
        end
        if (gold_vld) begin
            gold_c[gold_idx] = 1'b1;
        end
    end

`ifdef PORT_ALLOC_STARVE_EN
    localparam logic [PAS_CNT_W-1:0] STARVE_THR = PAS_CNT_W'(STARVE_TH);

    logic [PAS_CNT_W-1:0] cnt_q [NUM_PORT];
    logic [PAS_CNT_W-1:0] cnt_d [NUM_PORT];

    always_comb begin
        gold_vld = 1'b0;
        gold_idx = '0;
        for (int i = NUM_PORT - 1; i >= 0; i--) begin
            if (in_valid[i] && (cnt_q[i] >= STARVE_THR)) begin
                gold_vld = STARVE_ON;
                gold_idx = IW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (in_valid[i]) begin
                if (!defl_c[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != PAS_CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    assign gold_vld = STARVE_ON;
    assign gold_idx = '0;
`endif

    always_comb begin
        rr_d = rr_q;
        if (|in_valid) begin
            rr_d = (rr_q == LAST) ? '0 : rr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q          <= '0;
            out_valid_q   <= '0;
            out_grant_q   <= '0;
            out_deflect_q <= '0;
            out_golden_q  <= '0;
        end else begin
            rr_q          <= rr_d;
            out_valid_q   <= in_valid;
            out_grant_q   <= grant_c;
            out_deflect_q <= defl_c;
            out_golden_q  <= gold_c;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_grant   = out_grant_q;
    assign out_deflect = out_deflect_q;
    assign out_golden  = out_golden_q;

endmodule

// File: tb/tb_port_alloc_sched.sv
// Randomized bench for port_alloc_sched against a behavioural allocation model,
// plus directed cases with literal expectations.
`timescale 1ns/1ps
module tb_port_alloc_sched;

    localparam int N  = 4;
    localparam int TH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*N-1:0] in_ppv;
    logic [N-1:0]   out_valid;
    logic [N*N-1:0] out_grant;
    logic [N-1:0]   out_deflect;
    logic [N-1:0]   out_golden;

    int n_cmp = 0;
    int n_bad = 0;

    int m_rr;
    int m_cnt [N];

    logic [N-1:0]   e_valid;
    logic [N-1:0]   e_defl;
    logic [N-1:0]   e_gold;
    logic [N*N-1:0] e_grant;

    always #5 clk = ~clk;

    port_alloc_sched #(
        .NUM_PORT  (N),
        .STARVE_TH (TH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ppv      (in_ppv),
        .out_valid   (out_valid),
        .out_grant   (out_grant),
        .out_deflect (out_deflect),
        .out_golden  (out_golden)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Allocation computed from the priority/avail rules with plain ints and a queue
    task automatic model_step();
        int         gold;
        int         ord [$];
        logic [N-1:0] avail;
        gold    = -1;
        avail   = '1;
        e_valid = in_valid;
        e_grant = '0;
        e_defl  = '0;
        e_gold  = '0;
`ifdef PORT_ALLOC_STARVE_EN
        for (int i = 0; i < N; i++)
            if (gold < 0 && in_valid[i] && m_cnt[i] >= TH) gold = i;
`endif
        if (gold >= 0) begin
            ord.push_back(gold);
            e_gold[gold] = 1'b1;
        end
        for (int k = 0; k < N; k++)
            if ((m_rr + k) % N != gold) ord.push_back((m_rr + k) % N);
        foreach (ord[j]) begin
            int           i;
            int           p;
            bit           d;
            logic [N-1:0] pp;
            logic [N-1:0] want;
            i = ord[j];
            if (!in_valid[i]) continue;
            pp   = in_ppv[i*N +: N];
            want = pp & avail;
            d    = 1'b0;
            if (pp == 0) want = avail;
            else if (want == 0) begin
                want = avail;
                d    = 1'b1;
            end
            p = -1;
            for (int b = N - 1; b >= 0; b--) if (want[b]) p = b;
            if (p >= 0) begin
                e_grant[i*N + p] = 1'b1;
                avail[p]         = 1'b0;
            end
            e_defl[i] = d;
            m_cnt[i]  = d ? ((m_cnt[i] < 7) ? m_cnt[i] + 1 : 7) : 0;
        end
        if (|in_valid) m_rr = (m_rr + 1) % N;
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_grant", 32'(out_grant), 32'(e_grant));
        chk("out_deflect", 32'(out_deflect), 32'(e_defl));
        chk("out_golden", 32'(out_golden), 32'(e_gold));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_grant"}, 32'(out_grant), 32'h0);
        chk({tag, "_defl"}, 32'(out_deflect), 32'h0);
        chk({tag, "_gold"}, 32'(out_golden), 32'h0);
    endtask

    // reset dropped mid-cycle with all inputs valid; the flit at the edge is lost
    task automatic do_reset();
        in_valid = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [N-1:0] rand_ppv();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return '0;
        if (r == 1) return N'($urandom_range(0, 15));
        return N'(1) << $urandom_range(0, N - 1);
    endfunction

    task automatic set_rand();
        in_valid = N'($urandom_range(0, 15));
        for (int i = 0; i < N; i++) in_ppv[i*N +: N] = rand_ppv();
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 4'hF;
        in_ppv   = 16'h1248;
        model_reset();
        #2;
        chk_zero("reset_state");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_discard");
        reset = 1'b1;

        // rr = 0: input 0 wins port 1, input 1 deflected to port 0
        in_valid = 4'b0011;
        in_ppv   = {4'h0, 4'h0, 4'b0010, 4'b0010};
        cycle();
        chk("r029_g0", 32'(out_grant[3:0]), 32'b0010);
        chk("r029_g1", 32'(out_grant[7:4]), 32'b0001);
        chk("r029_defl", 32'(out_deflect), 32'b0010);

        // rr = 1: same stimulus, roles swap
        cycle();
        chk("r030_g1", 32'(out_grant[7:4]), 32'b0010);
        chk("r030_g0", 32'(out_grant[3:0]), 32'b0001);
        chk("r030_defl", 32'(out_deflect), 32'b0001);

        // idle cycle registers zeros and holds rr at 2
        in_valid = 4'h0;
        in_ppv   = 16'hFFFF;
        cycle();
        chk("idle_grant", 32'(out_grant), 32'h0);

        // rr = 2: everyone wants port 0; input 2 gets it, three deflect
        in_valid = 4'hF;
        in_ppv   = 16'h1111;
        cycle();
        chk("r032_union", 32'(out_grant[3:0] | out_grant[7:4] |
                               out_grant[11:8] | out_grant[15:12]), 32'hF);
        chk("r032_ndefl", 32'($countones(out_deflect)), 32'd3);
        chk("r032_defl", 32'(out_deflect), 32'b1011);
        chk("r032_g2", 32'(out_grant[11:8]), 32'b0001);

        do_reset();
        // single input, productive port 2; rr moves to 1
        in_valid = 4'b0001;
        in_ppv   = {4'h0, 4'h0, 4'h0, 4'b0100};
        cycle();
        chk("r028_g0", 32'(out_grant[3:0]), 32'b0100);
        chk("r028_defl", 32'(out_deflect), 32'b0000);
        in_valid = 4'b0011;
        in_ppv   = {4'h0, 4'h0, 4'b0010, 4'b0010};
        cycle();
        chk("r028_rr1", 32'(out_grant[7:4]), 32'b0010);

        do_reset();
        // input 3 loses port 0 repeatedly until it turns golden
        in_ppv = 16'h1111;
        in_valid = 4'b1001; cycle();
        in_valid = 4'b1010; cycle();
        in_valid = 4'b1100; cycle();
        chk("starve_defl3", 32'(out_deflect), 32'b1000);
        in_valid = 4'b0001; cycle();
        in_valid = 4'b1001; cycle();
        chk("starve_g3_4th", 32'(out_grant[15:12]), 32'b0010);
        in_valid = 4'b1010; cycle();
`ifdef PORT_ALLOC_STARVE_EN
        chk("r031_golden", 32'(out_golden), 32'b1000);
        chk("r031_g3", 32'(out_grant[15:12]), 32'b0001);
        chk("r031_defl", 32'(out_deflect), 32'b0010);
`else
        chk("rr_only_golden", 32'(out_golden), 32'b0000);
        chk("rr_only_g1", 32'(out_grant[7:4]), 32'b0001);
        chk("rr_only_defl", 32'(out_deflect), 32'b1000);
`endif
        in_valid = 4'b1100; cycle();
        chk("r031_cleared", 32'(out_golden), 32'b0000);
        chk("r031_g2", 32'(out_grant[11:8]), 32'b0001);

        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            set_rand();
            if ($urandom_range(0, 3) == 0) in_valid = 4'hF;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
